// File: rtl/alu_serial64.sv
// Bit-serial ALU: one full-adder slice plus one AND/OR/XOR gate, processing operands LSB first.
// Latency: result and flags valid exactly WIDTH cycles after the accept edge.
// Backpressure: result/flags hold in DONE until out_ready; in_ready is low from accept until the cycle after the handshake.
module alu_serial64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    // Single slice operands and results for the bit currently addressed by the counter.
    logic             a_bit, b_bit, b_eff;
    logic             sum_bit, slice_cout, res_bit;
    logic [WIDTH-1:0] shifted;
    logic             is_arith;

    // Datapath slice: full adder (B inverted for subtract) and the three logic gates, muxed by opcode.
    always_comb begin
        a_bit      = a_q[cnt_q];
        b_bit      = b_q[cnt_q];
        b_eff      = (op_q == OP_SUB) ? ~b_bit : b_bit;
        sum_bit    = a_bit ^ b_eff ^ carry_q;
        slice_cout = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        case (op_q)
            OP_PASSB:       res_bit = b_bit;
            OP_ADD, OP_SUB: res_bit = sum_bit;
            OP_AND:         res_bit = a_bit & b_bit;
            OP_OR:          res_bit = a_bit | b_bit;
            OP_XOR:         res_bit = a_bit ^ b_bit;
            default:        res_bit = 1'b0;
        endcase
        shifted = {res_bit, res_q[WIDTH-1:1]};
    end

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = cntrl;
                    cnt_d   = '0;
                    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                    carry_d = (cntrl == OP_SUB);
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = shifted;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Flags are latched on the final slice so they appear together with out_valid.
                    neg_d   = res_bit;
                    zero_d  = (shifted == '0);
                    cout_d  = is_arith & slice_cout;
                    ovf_d   = is_arith & (carry_q ^ slice_cout);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
        end
    end

    assign result    = res_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: doc/alu_serial64.md
ALU_SERIAL64 -- requirements
Module: alu_serial64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, high when an operation is offered.
REQ-005 SHALL have port in_ready, output, 1, high when an operation can be accepted.
REQ-006 SHALL have ports A and B, input, WIDTH each, the operands.
REQ-007 SHALL have port cntrl, input, 3, the opcode: 000 pass B, 010 add, 011 subtract, 100 AND, 101 OR, 110 XOR.
REQ-008 SHALL have port out_valid, output, 1, high when the result and flags are presented.
REQ-009 SHALL have port out_ready, input, 1, high when the consumer takes the result.
REQ-010 SHALL have port result, output, WIDTH, the operation result.
REQ-011 SHALL have ports negative, zero, overflow and carry_out, output, 1 each, the status flags.

Function
REQ-012 SHALL implement a three-state FSM (IDLE, RUN, DONE) that processes one bit per cycle, LSB first, using one full-adder slice and one each of the AND, OR and XOR gates.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; the two are never high together.
REQ-014 IDLE: on a clk edge with in_valid=1, SHALL capture A, B and cntrl, clear the bit counter and go to RUN.
REQ-015 The serial carry SHALL be initialised to 1 for subtract and to 0 for every other opcode.
REQ-016 RUN: each cycle SHALL compute bit[count] of the selected operation and shift it into the result register.
REQ-017 For subtract, RUN SHALL add A + ~B + carry.
REQ-018 RUN: SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL wrap to 0 on the RUN-to-DONE edge.
REQ-020 DONE: result and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 DONE: on an edge with out_ready=1, SHALL go to IDLE; in_ready SHALL rise the following cycle.
REQ-022 No back-to-back bypass: a new operation SHALL be accepted no earlier than one cycle after the DONE handshake.
REQ-023 in_valid, A, B and cntrl SHALL be ignored outside IDLE; input changes during RUN SHALL not affect the result.
REQ-024 negative SHALL equal result[WIDTH-1]; zero SHALL be 1 when result is all zeros.
REQ-025 For add and subtract, carry_out SHALL be the carry out of bit WIDTH-1, and overflow SHALL be the carry into bit WIDTH-1 XOR the carry out of it.
REQ-026 For subtract, carry_out=1 SHALL mean no borrow.
REQ-027 For pass B, AND, OR and XOR, overflow and carry_out SHALL be 0.
REQ-028 Opcodes 001 and 111 SHALL produce result 0, with zero=1 and all other flags 0, and SHALL use the same WIDTH-cycle latency.
REQ-029 Flags SHALL be registered and SHALL become valid in the same cycle as out_valid.

Reset
REQ-030 reset_n low SHALL immediately, without waiting for clk, force state IDLE.
REQ-031 reset_n low SHALL immediately force in_ready=1, out_valid=0, result=0, all flags=0, counter=0 and carry=0.
REQ-032 Reset asserted during RUN or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-033 After reset_n deasserts, the first rising clk edge with in_valid=1 SHALL be accepted normally.

Verification (WIDTH=64)
REQ-034 Add 5+3: cntrl=010, A=5, B=3 -> result 8, all flags 0, out_valid exactly 64 cycles after accept.
REQ-035 Subtract 3-5: cntrl=011 -> result 0xFFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0, overflow=0, zero=0.
REQ-036 Add overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> result 0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0.
REQ-037 Add carry: A=0xFFFF_FFFF_FFFF_FFFF, B=1, add -> result 0, zero=1, carry_out=1, overflow=0.
REQ-038 Backpressure: XOR of A=0xF0F0_F0F0_F0F0_F0F0 and B=0xFF00_FF00_FF00_FF00 with out_ready held low 10 cycles -> result 0x0FF0_0FF0_0FF0_0FF0 held stable, in_ready=0; random in_valid, A and B pulses during RUN have no effect.
REQ-039 Reset mid-run: reset_n low at bit count 20 -> out_valid=0 and in_ready=1 immediately; no result for that operation; the next add 1+1 gives 2.
